// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types for the radix-4 FFT output reorder stage
package fft_pkg;

  localparam int CPLX_WIDTH = 27;

  typedef struct packed {
    logic signed [CPLX_WIDTH-1:0] r;
    logic signed [CPLX_WIDTH-1:0] i;
  } cplx_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  typedef enum logic [1:0] {IDLE, READ, FLUSH} rd_state_e;

endpackage

// File: rtl/reorder_bank_ram.sv
// rtl/reorder_bank_ram.sv - one reorder bank: 4-lane write, single-lane 1-cycle read
module reorder_bank_ram #(
  parameter int DW = 54,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  input  logic [DW-1:0] wdata3,
  input  logic [1:0]    rlane,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [4][2**AW];
  logic [DW-1:0] rdata_d, rdata_q;

  always_comb rdata_d = mem[rlane][raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0][waddr] <= wdata0;
      mem[1][waddr] <= wdata1;
      mem[2][waddr] <= wdata2;
      mem[3][waddr] <= wdata3;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft4_out_reorder.sv
// rtl/fft4_out_reorder.sv - ping-pong capture of radix-4 groups, natural-order streaming out
module fft4_out_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 27,
  parameter int IDX_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IDX_WIDTH-1:0]  in_index,
  input  logic [DATA_WIDTH-1:0] in_y0_r,
  input  logic [DATA_WIDTH-1:0] in_y0_i,
  input  logic [DATA_WIDTH-1:0] in_y1_r,
  input  logic [DATA_WIDTH-1:0] in_y1_i,
  input  logic [DATA_WIDTH-1:0] in_y2_r,
  input  logic [DATA_WIDTH-1:0] in_y2_i,
  input  logic [DATA_WIDTH-1:0] in_y3_r,
  input  logic [DATA_WIDTH-1:0] in_y3_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [IDX_WIDTH+1:0]  out_k,
  output logic                  out_last,
  output logic                  overflow
);

  localparam int KW = IDX_WIDTH + 2;
  localparam int WW = 2 * DATA_WIDTH;

  bank_state_e          bank_state_q [2], bank_state_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic [IDX_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                 overflow_q, overflow_d;
  rd_state_e            rd_state_q, rd_state_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [KW-1:0]        rd_k_q, rd_k_d;
  logic                 p_v_q, p_v_d, p_bank_q, p_bank_d;
  logic [KW-1:0]        p_k_q, p_k_d;
  logic                 s_v_q, s_v_d, s_bank_q, s_bank_d;
  logic [KW-1:0]        s_k_q, s_k_d;
  logic [WW-1:0]        s_data_q, s_data_d;
  logic                 o_v_q, o_v_d, o_bank_q, o_bank_d;
  logic [KW-1:0]        o_k_q, o_k_d;
  logic [WW-1:0]        o_data_q, o_data_d;

  logic          writable, wr_en, issue, rd_start, release_bank, can_issue;
  logic [1:0]    fill;
  logic [WW-1:0] ram_rdata [2];
  logic [WW-1:0] p_data;

  assign writable     = (bank_state_q[wr_bank_q] == EMPTY) || (bank_state_q[wr_bank_q] == FILLING);
  assign release_bank = o_v_q && out_ready && (&o_k_q);
  assign p_data       = p_bank_q ? ram_rdata[1] : ram_rdata[0];

  // Credit rule: issue only if the sample would still fit in out+skid when it lands.
  assign fill      = 2'(o_v_q) + 2'(s_v_q) + 2'(p_v_q);
  assign can_issue = fill <= (2'(o_v_q && out_ready) + 2'd1);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_k_d     = rd_k_q;
    issue      = 1'b0;
    rd_start   = 1'b0;
    case (rd_state_q)
      READ: begin
        if (can_issue) begin
          issue  = 1'b1;
          rd_k_d = rd_k_q + 1'b1;
          if (&rd_k_q) begin
            rd_state_d = FLUSH;
            rd_bank_d  = !rd_bank_q;
          end
        end
      end
      default: begin
        if (can_issue && bank_state_q[rd_bank_q] == FULL) begin
          issue      = 1'b1;
          rd_start   = 1'b1;
          rd_k_d     = rd_k_q + 1'b1;
          rd_state_d = READ;
        end else if (rd_state_q == FLUSH && release_bank) begin
          rd_state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    bank_state_d = bank_state_q;
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = wr_cnt_q;
    overflow_d   = overflow_q;
    wr_en        = 1'b0;
    if (in_valid) begin
      if (writable) begin
        wr_en    = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        bank_state_d[wr_bank_q] = (&wr_cnt_q) ? FULL : FILLING;
      end else begin
        overflow_d = 1'b1;
      end
    end
    if (release_bank) bank_state_d[o_bank_q] = EMPTY;
    if (rd_start) bank_state_d[rd_bank_q] = DRAINING;
    // Looking at next-state lets a bank released this cycle be written from the next one.
    if ((bank_state_d[wr_bank_q] == FULL || bank_state_d[wr_bank_q] == DRAINING) &&
        bank_state_d[!wr_bank_q] == EMPTY)
      wr_bank_d = !wr_bank_q;
  end

  always_comb begin
    p_v_d    = issue;
    p_k_d    = rd_k_q;
    p_bank_d = rd_bank_q;
    o_v_d    = o_v_q;
    o_k_d    = o_k_q;
    o_data_d = o_data_q;
    o_bank_d = o_bank_q;
    s_v_d    = s_v_q;
    s_k_d    = s_k_q;
    s_data_d = s_data_q;
    s_bank_d = s_bank_q;
    if (o_v_q && !out_ready) begin
      if (!s_v_q && p_v_q) begin
        s_v_d    = 1'b1;
        s_k_d    = p_k_q;
        s_data_d = p_data;
        s_bank_d = p_bank_q;
      end
    end else if (s_v_q) begin
      o_v_d    = 1'b1;
      o_k_d    = s_k_q;
      o_data_d = s_data_q;
      o_bank_d = s_bank_q;
      s_v_d    = p_v_q;
      s_k_d    = p_k_q;
      s_data_d = p_data;
      s_bank_d = p_bank_q;
    end else begin
      o_v_d = p_v_q;
      if (p_v_q) begin
        o_k_d    = p_k_q;
        o_data_d = p_data;
        o_bank_d = p_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state_q[0] <= EMPTY;
      bank_state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      overflow_q <= 1'b0;
      rd_state_q <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_k_q     <= '0;
      p_v_q      <= 1'b0;
      p_k_q      <= '0;
      p_bank_q   <= 1'b0;
      s_v_q      <= 1'b0;
      s_k_q      <= '0;
      s_data_q   <= '0;
      s_bank_q   <= 1'b0;
      o_v_q      <= 1'b0;
      o_k_q      <= '0;
      o_data_q   <= '0;
      o_bank_q   <= 1'b0;
    end else begin
      bank_state_q <= bank_state_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      overflow_q <= overflow_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_k_q     <= rd_k_d;
      p_v_q      <= p_v_d;
      p_k_q      <= p_k_d;
      p_bank_q   <= p_bank_d;
      s_v_q      <= s_v_d;
      s_k_q      <= s_k_d;
      s_data_q   <= s_data_d;
      s_bank_q   <= s_bank_d;
      o_v_q      <= o_v_d;
      o_k_q      <= o_k_d;
      o_data_q   <= o_data_d;
      o_bank_q   <= o_bank_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank_ram #(
      .DW(WW),
      .AW(IDX_WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (wr_en && (wr_bank_q == 1'(b))),
      .waddr (in_index),
      .wdata0({in_y0_r, in_y0_i}),
      .wdata1({in_y1_r, in_y1_i}),
      .wdata2({in_y2_r, in_y2_i}),
      .wdata3({in_y3_r, in_y3_i}),
      .rlane (rd_k_q[KW-1:IDX_WIDTH]),
      .raddr (rd_k_q[IDX_WIDTH-1:0]),
      .rdata (ram_rdata[b])
    );
  end

  assign out_valid = o_v_q;
  assign out_r     = o_data_q[WW-1:DATA_WIDTH];
  assign out_i     = o_data_q[DATA_WIDTH-1:0];
  assign out_k     = o_k_q;
  assign out_last  = o_v_q && (&o_k_q);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft4_out_reorder.sv
// tb/tb_fft4_out_reorder.sv - randomized scoreboard bench for fft4_out_reorder
module tb_fft4_out_reorder;
  import fft_pkg::*;

  localparam int DW = 27;
  localparam int IW = 2;
  localparam int G  = 1 << IW;
  localparam int N  = 4 * G;
  localparam int KW = IW + 2;

  typedef struct {
    int    k;
    cplx_t d;
    bit    last;
  } exp_t;

  logic                 clk = 0;
  logic                 rst = 1;
  logic                 in_valid = 0;
  logic [IW-1:0]        in_index = '0;
  logic [DW-1:0]        yr [4];
  logic [DW-1:0]        yi [4];
  logic                 out_valid;
  logic                 out_ready = 0;
  logic [DW-1:0]        out_r, out_i;
  logic [KW-1:0]        out_k;
  logic                 out_last;
  logic                 overflow;

  fft4_out_reorder #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index),
    .in_y0_r(yr[0]), .in_y0_i(yi[0]), .in_y1_r(yr[1]), .in_y1_i(yi[1]),
    .in_y2_r(yr[2]), .in_y2_i(yi[2]), .in_y3_r(yr[3]), .in_y3_i(yi[3]),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
    .out_k(out_k), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  cplx_t fb [4][G];
  int    part_cnt = 0;
  int    held = 0;
  bit    exp_ovf = 0;
  int    hs_cnt = 0;
  int    run_cur = 0;
  int    run_last = 0;
  bit    stall_pend = 0;
  logic [63:0] stall_snap;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a frame is a 4xG matrix; output k reads lane k/G, group k%G.
  task automatic model_group(input int idx, input cplx_t v[4]);
    if (held >= 2) begin
      exp_ovf = 1;
    end else begin
      for (int j = 0; j < 4; j++) fb[j][idx] = v[j];
      part_cnt++;
      if (part_cnt == G) begin
        for (int k = 0; k < N; k++) exp_q.push_back('{k: k, d: fb[k / G][k % G], last: (k == N - 1)});
        part_cnt = 0;
        held++;
      end
    end
  endtask

  task automatic send_group(input int idx, input bit ramp);
    cplx_t v[4];
    for (int j = 0; j < 4; j++) begin
      v[j].r = ramp ? 27'(16 * j + idx) : 27'($urandom);
      v[j].i = 27'($urandom);
      yr[j]  = v[j].r;
      yi[j]  = v[j].i;
    end
    in_index = IW'(idx);
    in_valid = 1;
    model_group(idx, v);
    tick();
    in_valid = 0;
  endtask

  task automatic send_frame(input bit reverse, input bit ramp);
    for (int g = 0; g < G; g++) send_group(reverse ? G - 1 - g : g, ramp);
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 2000) begin
      tick();
      c++;
    end
    check(c < 2000, name, 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [63:0] act, req;
    if (rst) begin
      stall_pend = 0;
      run_cur    = 0;
    end else begin
      act = {1'b0, out_k, out_r, out_i, out_last};
      if (stall_pend) check(out_valid && act == stall_snap, "stable_while_stalled", act, stall_snap);
      stall_pend = out_valid && !out_ready;
      stall_snap = act;
      if (out_valid) run_cur++;
      else begin
        if (run_cur != 0) run_last = run_cur;
        run_cur = 0;
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check(0, "unexpected_sample", act, 64'd0);
        end else begin
          e = exp_q.pop_front();
          req = {1'b0, KW'(e.k), e.d.r, e.d.i, e.last};
          check(act == req, "sample", act, req);
        end
        if (out_last && held > 0) held--;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int c;
    for (int j = 0; j < 4; j++) begin
      yr[j] = '0;
      yi[j] = '0;
    end
    repeat (3) tick();
    rst = 0;
    check(out_valid == 0, "reset_out_valid", 64'(out_valid), 64'd0);
    check(out_last == 0, "reset_out_last", 64'(out_last), 64'd0);
    check(overflow == 0, "reset_overflow", 64'(overflow), 64'd0);
    check({out_k, out_r, out_i} == '0, "reset_out_data", 64'({out_k, out_r, out_i}), 64'd0);

    // Ramp frame in order, with exact latency after the final write.
    out_ready = 1;
    hs_cnt = 0;
    send_frame(0, 1);
    tick();
    check(out_valid == 0, "latency_t_plus_1", 64'(out_valid), 64'd0);
    tick();
    check(out_valid == 1 && out_k == 0, "latency_t_plus_2", 64'({out_valid, out_k}), 64'({1'b1, 4'd0}));
    wait_drain("drain_ordered");
    check(hs_cnt == N, "hs_ordered", 64'(hs_cnt), 64'(N));
    check(run_last == N, "run_ordered", 64'(run_last), 64'(N));

    // Same ramp, reversed arrival order.
    hs_cnt = 0;
    send_frame(1, 1);
    wait_drain("drain_reversed");
    check(hs_cnt == N, "hs_reversed", 64'(hs_cnt), 64'(N));

    // Random back-pressure.
    hs_cnt = 0;
    send_frame(0, 0);
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    out_ready = 1;
    check(c < 2000, "drain_backpressure", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    check(hs_cnt == N, "hs_backpressure", 64'(hs_cnt), 64'(N));

    // Back-to-back frames must stream without a bubble at the bank switch.
    hs_cnt = 0;
    run_last = 0;
    send_frame(0, 0);
    send_frame(1, 0);
    wait_drain("drain_b2b");
    check(hs_cnt == 2 * N, "hs_b2b", 64'(hs_cnt), 64'(2 * N));
    check(run_last == 2 * N, "run_b2b", 64'(run_last), 64'(2 * N));

    // Three frames with the consumer stalled: third is dropped.
    out_ready = 0;
    hs_cnt = 0;
    send_frame(0, 0);
    send_frame(0, 0);
    check(overflow == 0, "no_overflow_two_frames", 64'(overflow), 64'd0);
    send_frame(0, 0);
    repeat (4) tick();
    check(overflow == exp_ovf, "overflow_set", 64'(overflow), 64'(exp_ovf));
    check(out_valid == 1, "stalled_valid", 64'(out_valid), 64'd1);
    out_ready = 1;
    wait_drain("drain_overflow");
    check(hs_cnt == 2 * N, "hs_overflow", 64'(hs_cnt), 64'(2 * N));
    check(overflow == 1, "overflow_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a drain.
    send_frame(0, 0);
    c = 0;
    while (!(out_valid && out_k == 5) && c < 200) begin
      tick();
      c++;
    end
    check(c < 200, "reach_k5", 64'(out_k), 64'd5);
    rst = 1;
    exp_q.delete();
    held = 0;
    part_cnt = 0;
    exp_ovf = 0;
    tick();
    check(out_valid == 0, "rst_out_valid", 64'(out_valid), 64'd0);
    check(overflow == 0, "rst_overflow", 64'(overflow), 64'd0);
    rst = 0;
    tick();
    hs_cnt = 0;
    run_last = 0;
    send_frame(0, 0);
    wait_drain("drain_after_rst");
    check(hs_cnt == N, "hs_after_rst", 64'(hs_cnt), 64'(N));
    check(run_last == N, "run_after_rst", 64'(run_last), 64'(N));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft4_out_reorder.md
# fft4_out_reorder

Downstream stage of the parallel radix-4 twiddle/butterfly stage. It captures the four complex results produced per valid cycle, tagged with the group index, into a ping-pong buffer. It then streams a completed frame out one complex sample per cycle in natural frequency order, with valid/ready back-pressure toward the next consumer.

## Interface
Parameters:
- DATA_WIDTH, 27, width of each real/imag component
- IDX_WIDTH, 11, group index width; GROUPS = 2**IDX_WIDTH groups per frame, frame = 4*GROUPS samples

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream output-valid pulse; one group per asserted cycle; no back-pressure possible
- in_index  in  IDX_WIDTH  group index i of the current group
- in_y0_r … in_y3_i  in  DATA_WIDTH each (8 ports)  lane j real/imag, signed
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_r, out_i  out  DATA_WIDTH  output sample, signed, unmodified bits
- out_k  out  IDX_WIDTH+2  natural-order sample index k
- out_last  out  1  high with k = 4*GROUPS-1
- overflow  out  1  sticky, set when a group is dropped

## Operation
- Two banks, each 4 lanes × GROUPS words × 2*DATA_WIDTH bits. Lane j at address i holds in_yj of group i.
- Output order: k = j*GROUPS + i; read lane k[IDX_WIDTH+1:IDX_WIDTH], address k[IDX_WIDTH-1:0].
- Writer: the write pointer selects the bank in FILLING. Each in_valid writes all 4 lanes at in_index, addressed by in_index, not by arrival order. A write counter counts accepted groups.
- When the counter reaches GROUPS, the bank becomes FULL and the writer moves to the other bank, provided that bank is EMPTY.
- Bank states: EMPTY → FILLING (first write) → FULL (GROUPS writes) → DRAINING (reader starts) → EMPTY (out_last handshake).
- If the next bank is not EMPTY, the writer waits.
- in_valid arriving while no bank is writable: group dropped, overflow set (cleared only by rst), write counter unchanged.
- Reader FSM states:
  - IDLE: start when a FULL bank exists, oldest first.
  - READ: issue addresses k = 0…4*GROUPS-1.
  - FLUSH: last sample held until accepted.
  - Return to IDLE, or chain directly into the other bank if it is FULL, with no bubble.
- Back-pressure: while out_valid && !out_ready, out_r/out_i/out_k/out_last stay stable. Use a 2-entry skid on the RAM read path so the throughput is 1 sample/cycle with out_ready held high.
- Simultaneous case: the reader releases bank B (out_last handshake) in the same cycle the writer completes bank A. The writer may target B starting the next cycle.
- Duplicate in_index within a frame overwrites the word and still counts. Not checked.

## Timing
- Reset values: out_valid=0, out_last=0, overflow=0, out_r/out_i/out_k=0, both banks EMPTY, writer on bank 0, reader IDLE.
- Write: data registered at the edge where in_valid=1.
- Latency: the last write of a frame is captured at edge T. The bank is FULL after T, and out_valid=1 with k=0 is presented after edge T+2.
- With out_ready=1 continuously, one sample per cycle; 4*GROUPS consecutive valid cycles per frame.
- A bank becomes EMPTY at the edge after its out_last handshake.
- rst mid-frame: all state aborts in that cycle. Partial frame contents are discarded (not guaranteed zeroed); out_valid is 0 on the next cycle.

## Structure
- Shared package fft_pkg:
  - typedef for the complex sample struct {r, i} of DATA_WIDTH.
  - bank-state enum {EMPTY, FILLING, FULL, DRAINING}.
  - reader-state enum {IDLE, READ, FLUSH}.
- One sub-module, reorder_bank_ram: a simple dual-port RAM, 1-cycle synchronous read, with a 4-lane write and a single-lane read. Instantiate it twice, one per bank.
- Writer control, reader FSM and skid buffer live in the top.

## Test plan
- IDX_WIDTH=2, in_valid for 4 cycles, index 0..3, lane j value = 16*j+i → outputs k=0..15 values 0,1,2,3,16,17,…,51; out_last at k=15; first out_valid 2 cycles after the last write.
- Same frame, indices sent 3,2,1,0 → identical output order and values.
- Back-pressure: out_ready toggled 1/0 randomly → no sample lost or duplicated; outputs stable while stalled; 16 handshakes total.
- Two back-to-back frames, out_ready=1 → 32 consecutive valid cycles, no bubble at the bank switch.
- out_ready=0 while three frames are sent → third frame's first group sets overflow; the first two frames drain intact afterward.
- rst asserted at k=5 of the drain → out_valid=0 next cycle, overflow=0; a fresh frame afterward outputs correctly from k=0.
